wishbone_master_ctrl: RTL
=========================

Name: wishbone_master_ctrl

Overview:
Single-outstanding Wishbone classic master that sits directly upstream of wishbone_slave and drives its adr/dat_mosi/we/cyc/stb and consumes dat_miso/ack.
- Converts a valid/ready command stream from the host-side logic into one Wishbone cycle per command.
- Returns the result on a valid/ready response stream.
- Only one transaction is in flight at a time. No pipelining and no burst support.

Parameters:
ADR_W, 4, Wishbone address width; matches the slave's adr.
DAT_W, 32, Wishbone data width.
TIMEOUT_CYCLES, 16, maximum cycles spent in BUS before abort; used only when the timeout feature is compiled in; legal range 1..255.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  asynchronous active-high reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  master can accept a command.
cmd_we  input  1  1 = write, 0 = read.
cmd_adr  input  ADR_W  target address.
cmd_dat  input  DAT_W  write data; ignored for reads.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer accepts the response.
rsp_we  output  1  echo of cmd_we for this transaction.
rsp_dat  output  DAT_W  read data; 0 for writes.
rsp_err  output  1  transaction aborted by timeout.
busy  output  1  high in BUS or RESP.
adr  output  ADR_W  Wishbone address.
dat_mosi  output  DAT_W  Wishbone write data.
dat_miso  input  DAT_W  Wishbone read data.
we  output  1  Wishbone write enable.
cyc  output  1  Wishbone cycle.
stb  output  1  Wishbone strobe.
ack  input  1  Wishbone acknowledge.

Behaviour:
- Reset values: all outputs are driven from registers. After rst asserts, every output is 0 except cmd_ready, which resets to 1. Reset takes effect immediately; it is not synchronised to clk.
- States: IDLE, BUS, RESP. The reset state is IDLE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid at a clk edge: register cmd_adr, cmd_dat and cmd_we onto adr, dat_mosi and we. Set cyc = stb = 1. Go to BUS.
  - dat_mosi is loaded with 0 for reads.
- BUS:
  - cmd_ready = 0.
  - adr, dat_mosi, we, cyc and stb are held stable until ack is sampled at 1.
  - On ack: clear cyc and stb. Capture rsp_dat = dat_miso for reads, or 0 for writes. Set rsp_we = we, rsp_err = 0, rsp_valid = 1. Go to RESP.
  - we, adr and dat_mosi return to 0 when cyc drops.
- RESP:
  - rsp_valid and the response payload are held until rsp_ready is sampled at 1.
  - Then rsp_valid clears, cmd_ready goes to 1, and the state returns to IDLE.
  - A new command cannot be accepted in the same edge that the response is consumed.
- Latency, counted from the command-accept edge E0:
  - cyc is high from E0 through the ack edge.
  - With a zero-wait slave (ack combinational on stb), ack is sampled at E1 and rsp_valid rises after E1.
  - Minimum spacing between accepted commands is 3 cycles.
- ack sampled at 1 in IDLE or RESP is ignored: no state change and no data capture.
- cmd_valid while cmd_ready = 0 is not accepted. The upstream side must hold the command.
- busy = (state != IDLE).
- rst asserted mid-BUS: cyc and stb drop immediately and the transaction is discarded. No response is produced.
- Throughout BUS, stb equals cyc. The master never asserts stb without cyc.

Optional Feature:
Macro WB_MASTER_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to BUS and increments on each BUS cycle with ack = 0.
  - When the counter reaches TIMEOUT_CYCLES with ack still 0: clear cyc and stb, and go to RESP with rsp_err = 1, rsp_dat = 0, and rsp_we = the echoed cmd_we.
  - If ack and the timeout condition occur in the same cycle, ack wins and rsp_err = 0.
- Not defined: no counter is built, BUS waits indefinitely for ack, and rsp_err is tied to 0.

Decomposition:
- Package wishbone_pkg holds:
  - the state enum wb_mst_state_t {IDLE, BUS, RESP};
  - constants WB_ADR_W = 4 and WB_DAT_W = 32, used as the parameter defaults;
  - a typedef wb_cmd_t struct {we, adr, dat} for the command payload register.
- One sub-module is natural: wb_timeout_cnt (counter plus compare, producing an expired pulse), instantiated only under WB_MASTER_TIMEOUT_EN.
- Everything else lives in one module.

Test Plan:
- Write via cmd (we=1, adr=4'h1, dat=32'hDEADBEEF) to wishbone_slave -> cyc/stb/we high for exactly 1 cycle, then rsp_valid with rsp_we=1, rsp_dat=0, rsp_err=0; busy is low after rsp_ready.
- Write adr=4'h2, dat=32'hCAFEBABE, then reads of adr 1 and adr 2 -> rsp_dat = 32'hDEADBEEF, then 32'hCAFEBABE.
- Slave ack delayed by 3 cycles -> adr, dat_mosi and we are stable for all 4 BUS cycles, cmd_ready=0 throughout, and the next cmd_valid is not accepted until after the response is consumed.
- rsp_ready held at 0 for 5 cycles -> rsp_valid and rsp_dat are stable and cmd_ready=0; a stray ack pulse during RESP changes nothing.
- rst pulse while in BUS -> cyc=stb=0 immediately (before the next edge), cmd_ready=1 and no rsp_valid.
- With WB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=4, ack tied to 0 -> cyc drops after 4 BUS cycles, then rsp_valid with rsp_err=1 and rsp_dat=0. Without the macro: cyc stays high for 100 cycles.

Source files
------------

// File: rtl/wishbone_pkg.sv
// Shared types and default widths for the single-outstanding Wishbone master.
package wishbone_pkg;

    localparam int unsigned WB_ADR_W = 4;
    localparam int unsigned WB_DAT_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_mst_state_t;

    // Command payload as it is driven onto the bus
    typedef struct packed {
        logic                we;
        logic [WB_ADR_W-1:0] adr;
        logic [WB_DAT_W-1:0] dat;
    } wb_cmd_t;

endpackage

// File: rtl/wishbone_master_ctrl_timeout.sv
// BUS wait counter for wishbone_master_ctrl; instantiated only with WB_MASTER_TIMEOUT_EN.
module wb_timeout_cnt #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic ack,
    output logic expired_c
);
    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] cnt_q;

    // Held at zero outside BUS so every transaction starts from a clean count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!run) begin
            cnt_q <= '0;
        end else if (!ack) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Fires on the edge at which the count would reach LIMIT with no ack
    assign expired_c = run && !ack && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/wishbone_master_ctrl.sv
// Single-outstanding Wishbone classic master: valid/ready command in, one bus cycle, valid/ready response out.
// Optional bus timeout abort is compiled in with WB_MASTER_TIMEOUT_EN.
module wishbone_master_ctrl
    import wishbone_pkg::*;
#(
    parameter int unsigned ADR_W          = WB_ADR_W,
    parameter int unsigned DAT_W          = WB_DAT_W,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [ADR_W-1:0] cmd_adr,
    input  logic [DAT_W-1:0] cmd_dat,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_we,
    output logic [DAT_W-1:0] rsp_dat,
    output logic             rsp_err,
    output logic             busy,
    output logic [ADR_W-1:0] adr,
    output logic [DAT_W-1:0] dat_mosi,
    input  logic [DAT_W-1:0] dat_miso,
    output logic             we,
    output logic             cyc,
    output logic             stb,
    input  logic             ack
);

    wb_mst_state_t    state_q, state_d;
    wb_cmd_t          bus_q, bus_d;
    logic             cyc_q, cyc_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             busy_q, busy_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_we_q, rsp_we_d;
    logic [DAT_W-1:0] rsp_dat_q, rsp_dat_d;
    logic             rsp_err_q, rsp_err_d;
    logic             timeout_c;

`ifdef WB_MASTER_TIMEOUT_EN
    wb_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .run       (state_q == BUS),
        .ack       (ack),
        .expired_c (timeout_c)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^8'(TIMEOUT_CYCLES);
    assign timeout_c      = 1'b0;
`endif

    // State and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_q       <= '0;
            cyc_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_q       <= bus_d;
            cyc_q       <= cyc_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q    <= rsp_we_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next state and next output values
    always_comb begin
        state_d     = state_q;
        bus_d       = bus_q;
        cyc_d       = cyc_q;
        cmd_ready_d = cmd_ready_q;
        busy_d      = busy_q;
        rsp_valid_d = rsp_valid_q;
        rsp_we_d    = rsp_we_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    bus_d.we    = cmd_we;
                    bus_d.adr   = WB_ADR_W'(cmd_adr);
                    bus_d.dat   = cmd_we ? WB_DAT_W'(cmd_dat) : '0;
                    cyc_d       = 1'b1;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = BUS;
                end
            end
            BUS: begin
                // ack takes priority over a coincident timeout
                if (ack) begin
                    bus_d       = '0;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = bus_q.we;
                    rsp_dat_d   = bus_q.we ? '0 : dat_miso;
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
                end else if (timeout_c) begin
                    bus_d       = '0;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = bus_q.we;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_we_d    = 1'b0;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b0;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_we    = rsp_we_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign adr       = ADR_W'(bus_q.adr);
    assign dat_mosi  = DAT_W'(bus_q.dat);
    assign we        = bus_q.we;
    assign cyc       = cyc_q;
    assign stb       = cyc_q;

endmodule
